mac_acc_pipe: RTL and testbench

- Parametrised, pipelined N-lane dot-product MAC for the PE array.
- Each input beat multiplies LANES activations by LANES signed weights and reduces the products through an adder tree.
- Sums accumulate across a multi-beat burst delimited by first/last flags, seeded with an external partial sum.
- Final psum is saturated to PSUM_BW, with a sticky overflow flag.

---
 rtl/mac_acc_pipe_pkg.sv | 57 +++++
 rtl/mac_acc_pipe_if.sv | 31 +++
 rtl/mac_acc_pipe_tree.sv | 35 +++
 rtl/mac_acc_pipe.sv | 144 ++++++++++++++
 tb/tb_mac_acc_pipe.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mac_acc_pipe_pkg.sv
// Shared widths, FSM encoding and the psum saturation helper for the MAC pipe.
// The widths are derived from the module parameters, so the package provides them as functions.
`timescale 1ns/1ps
package mac_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_t;

  function automatic int prod_width(input int bw);
    return 2 * bw + 1;
  endfunction

  function automatic int tree_width(input int bw, input int lanes);
    return prod_width(bw) + $clog2(lanes);
  endfunction

  // The extra headroom bits mean that base + tree can never wrap before it is clamped.
  function automatic int wide_width(input int bw, input int psum_bw, input int lanes);
    return psum_bw + 1 + $clog2(lanes) + bw;
  endfunction

  // Widths for the default configuration: BW=4, PSUM_BW=16, LANES=4.
  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int LANES_DEF   = 4;
  localparam int PROD_W      = prod_width(BW_DEF);
  localparam int TREE_W      = tree_width(BW_DEF, LANES_DEF);
  localparam int WIDE_W      = wide_width(BW_DEF, PSUM_BW_DEF, LANES_DEF);

  // Clamps a sign-extended wide sum to the signed psum_bw range.
  // It also reports whether the sum lay outside that range.
  function automatic sat_t sat_psum(input logic signed [63:0] wide, input int psum_bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               res;
    hi      = (64'sd1 <<< (psum_bw - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    res.val = wide;
    res.ovf = 1'b0;
    if (wide > hi) begin
      res.val = hi;
      res.ovf = 1'b1;
    end else if (wide < lo) begin
      res.val = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_acc_pipe_if.sv
// Beat input / result output bundle for mac_acc_pipe.
// The DUT uses the slave modport and the beat source uses the master modport.
`timescale 1ns/1ps
interface mac_acc_pipe_if
  import mac_pkg::*;
#(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int LANES   = 4
);
  logic                      in_valid;
  logic                      in_first;
  logic                      in_last;
  logic                      a_signed;
  logic [LANES*BW-1:0]       a;
  logic [LANES*BW-1:0]       b;
  logic signed [PSUM_BW-1:0] c;
  logic                      out_valid;
  logic signed [PSUM_BW-1:0] out;
  logic                      out_ovf;

  modport master (
    output in_valid, in_first, in_last, a_signed, a, b, c,
    input  out_valid, out, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, a_signed, a, b, c,
    output out_valid, out, out_ovf
  );
endinterface

// File: rtl/mac_acc_pipe_tree.sv
// Combinational signed adder tree that reduces LANES products to one sum.
// Each level sums adjacent pairs of the level below it.
`timescale 1ns/1ps
module mac_tree
  import mac_pkg::*;
#(
  parameter  int BW        = 4,
  parameter  int LANES     = 4,
  localparam int PROD_BITS = prod_width(BW),
  localparam int TREE_BITS = tree_width(BW, LANES),
  localparam int LEVELS    = $clog2(LANES)
) (
  input  logic [LANES*PROD_BITS-1:0] prods,
  output logic signed [TREE_BITS-1:0] sum
);

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      logic signed [TREE_BITS-1:0] n [LANES >> gi];
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < LANES; gj++) begin : g_in
          assign n[gj] = TREE_BITS'($signed(prods[gj*PROD_BITS +: PROD_BITS]));
        end
      end else begin : g_sum
        for (gj = 0; gj < (LANES >> gi); gj++) begin : g_pair
          assign n[gj] = g_lvl[gi-1].n[2*gj] + g_lvl[gi-1].n[2*gj+1];
        end
      end
    end
  endgenerate

  assign sum = g_lvl[LEVELS].n[0];

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage N-lane dot-product MAC. P1 registers the lane products.
// P2 reduces them, accumulates over a first/last burst, and saturates the result.
`timescale 1ns/1ps
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter  int BW        = 4,
  parameter  int PSUM_BW   = 16,
  parameter  int LANES     = 4,
  parameter  bit SAT_EN    = 1'b1,
  localparam int PROD_BITS = prod_width(BW),
  localparam int TREE_BITS = tree_width(BW, LANES),
  localparam int WIDE_BITS = wide_width(BW, PSUM_BW, LANES)
) (
  input logic clk,
  input logic reset,
  mac_acc_pipe_if.slave bus
);

  // ---------------- P1: per-lane products ----------------
  logic [LANES*PROD_BITS-1:0] prod_flat;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [BW:0]          a_ext;
      logic signed [BW:0]          b_ext;
      logic signed [PROD_BITS-1:0] prod;
      assign a_ext = bus.a_signed ? {bus.a[gi*BW+BW-1], bus.a[gi*BW +: BW]}
                                  : {1'b0, bus.a[gi*BW +: BW]};
      assign b_ext = {bus.b[gi*BW+BW-1], bus.b[gi*BW +: BW]};
      assign prod  = PROD_BITS'(a_ext) * PROD_BITS'(b_ext);
      assign prod_flat[gi*PROD_BITS +: PROD_BITS] = prod;
    end
  endgenerate

  logic                       p1_valid_reg;
  logic                       p1_first_reg;
  logic                       p1_last_reg;
  logic signed [PSUM_BW-1:0]  p1_c_reg;
  logic [LANES*PROD_BITS-1:0] p1_prod_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      p1_valid_reg <= 1'b0;
      p1_first_reg <= 1'b0;
      p1_last_reg  <= 1'b0;
      p1_c_reg     <= '0;
      p1_prod_reg  <= '0;
    end else begin
      p1_valid_reg <= bus.in_valid;
      p1_first_reg <= bus.in_valid & bus.in_first;
      p1_last_reg  <= bus.in_valid & bus.in_last;
      p1_c_reg     <= bus.c;
      p1_prod_reg  <= prod_flat;
    end
  end

  // ---------------- P2: reduce and accumulate ----------------
  logic signed [TREE_BITS-1:0] tree_sum;

  mac_tree #(
    .BW    (BW),
    .LANES (LANES)
  ) u_tree (
    .prods (p1_prod_reg),
    .sum   (tree_sum)
  );

  logic signed [PSUM_BW-1:0]   acc_reg;
  logic                        ovf_reg;
  logic signed [WIDE_BITS-1:0] base_wide;
  logic signed [WIDE_BITS-1:0] tree_wide;
  logic signed [WIDE_BITS-1:0] wide_sum;
  sat_t                        sat_res;
  logic signed [PSUM_BW-1:0]   acc_next;
  logic                        ovf_next;

  always_comb begin
    base_wide = p1_first_reg ? WIDE_BITS'(p1_c_reg) : WIDE_BITS'(acc_reg);
    tree_wide = WIDE_BITS'(tree_sum);
    wide_sum  = base_wide + tree_wide;
    sat_res   = sat_psum(64'(wide_sum), PSUM_BW);
    acc_next  = SAT_EN ? sat_res.val[PSUM_BW-1:0] : wide_sum[PSUM_BW-1:0];
    ovf_next  = (p1_first_reg ? 1'b0 : ovf_reg) | sat_res.ovf;
  end

  // Bits above PSUM_BW of the clamped value only repeat its sign.
  logic unused_sat_hi;
  assign unused_sat_hi = ^sat_res.val[63:PSUM_BW];

  // Bubbles leave the accumulator and the sticky flag untouched, even mid-burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (p1_valid_reg) begin
      acc_reg <= acc_next;
      ovf_reg <= ovf_next;
    end
  end

  // ---------------- burst tracking ----------------
  acc_state_e state_reg;
  acc_state_e state_next;

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // A first while in ACC reseeds the accumulator, so the aborted burst needs no separate state.
  always_comb begin
    state_next = state_reg;
    if (p1_valid_reg) begin
      if (p1_last_reg)       state_next = ST_IDLE;
      else if (p1_first_reg) state_next = ST_ACC;
    end
  end

  // ---------------- output register ----------------
  logic                      out_valid_reg;
  logic signed [PSUM_BW-1:0] out_reg;
  logic                      out_ovf_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      out_valid_reg <= p1_valid_reg & p1_last_reg;
      if (p1_valid_reg && p1_last_reg) begin
        out_reg     <= acc_next;
        out_ovf_reg <= ovf_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe (BW=4, PSUM_BW=16, LANES=4, SAT_EN=1).
// The expected values are computed by hand from the lane arithmetic.
`timescale 1ns/1ps
module tb_mac_acc_pipe;
  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LANES   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_acc_pipe_if #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES)) bus ();

  mac_acc_pipe #(
    .BW      (BW),
    .PSUM_BW (PSUM_BW),
    .LANES   (LANES),
    .SAT_EN  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int p0;

  always @(negedge clk) if (bus.out_valid) pulses++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Presents one beat at a negedge; it is captured at the following posedge.
  task automatic beat(input bit f, input bit l, input bit s,
                      input logic [BW-1:0] av, input logic [BW-1:0] bv, input int c);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last  = l;
    bus.a_signed = s;
    bus.a        = {LANES{av}};
    bus.b        = {LANES{bv}};
    bus.c        = PSUM_BW'(c);
    @(negedge clk);
    idle();
  endtask

  task automatic expect_out(input string tag, input int exp, input bit exp_ovf);
    int waited = 0;
    while (!bus.out_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " valid"}, longint'(bus.out_valid), 1);
    check({tag, " out"}, longint'($signed(bus.out)), exp);
    check({tag, " ovf"}, longint'(bus.out_ovf), longint'(exp_ovf));
    $display("txn %s: out=%0d ovf=%0d", tag, $signed(bus.out), bus.out_ovf);
    @(negedge clk);
    check({tag, " pulse"}, longint'(bus.out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.a_signed = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst valid", longint'(bus.out_valid), 0);
    check("rst out", longint'($signed(bus.out)), 0);
    check("rst ovf", longint'(bus.out_ovf), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: unsigned 15 * -8 per lane = -480, plus 100; checks exact latency and hold
    beat(1, 1, 0, 4'hF, 4'h8, 100);
    check("t1 early", longint'(bus.out_valid), 0);
    @(negedge clk);
    check("t1 valid", longint'(bus.out_valid), 1);
    check("t1 out", longint'($signed(bus.out)), -380);
    check("t1 ovf", longint'(bus.out_ovf), 0);
    $display("txn t1: out=%0d ovf=%0d", $signed(bus.out), bus.out_ovf);
    @(negedge clk);
    check("t1 pulse", longint'(bus.out_valid), 0);
    check("t1 hold", longint'($signed(bus.out)), -380);

    // 2: 4'hF is -1 when signed, 15 when unsigned
    beat(1, 1, 1, 4'hF, 4'h7, 0);
    expect_out("t2 signed", -28, 1'b0);
    beat(1, 1, 0, 4'hF, 4'h7, 0);
    expect_out("t2 unsigned", 420, 1'b0);

    // 3: three beats of +4 with a bubble; first/last while invalid are ignored
    p0 = pulses;
    beat(1, 0, 0, 4'h1, 4'h1, 10);
    beat(0, 0, 0, 4'h1, 4'h1, 0);
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    bus.c        = 16'sd999;
    @(negedge clk);
    idle();
    @(negedge clk);
    check("t3 no early out", longint'(pulses - p0), 0);
    beat(0, 1, 0, 4'h1, 4'h1, 0);
    expect_out("t3 burst", 22, 1'b0);
    check("t3 pulse count", longint'(pulses - p0), 1);

    // 4: saturation on both rails, then the flag clears on the next first
    beat(1, 1, 0, 4'hF, 4'h7, 32760);
    expect_out("t4 pos sat", 32767, 1'b1);
    beat(1, 1, 0, 4'hF, 4'h8, -32768);
    expect_out("t4 neg sat", -32768, 1'b1);
    beat(1, 1, 0, 4'h1, 4'h1, 0);
    expect_out("t4 clear", 4, 1'b0);

    // 5: abort by a second first, then chain onto the result with a last-only beat
    p0 = pulses;
    beat(1, 0, 0, 4'h1, 4'h1, 5);
    beat(1, 1, 0, 4'h1, 4'h1, 1);
    expect_out("t5 abort", 5, 1'b0);
    beat(0, 1, 0, 4'h1, 4'h1, 0);
    expect_out("t5 chain", 9, 1'b0);
    check("t5 pulse count", longint'(pulses - p0), 2);

    // 6: reset mid-burst, then 2*3 per lane from a zero seed
    p0 = pulses;
    beat(1, 0, 0, 4'h1, 4'h1, 100);
    beat(0, 0, 0, 4'h1, 4'h1, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t6 rst valid", longint'(bus.out_valid), 0);
    check("t6 rst out", longint'($signed(bus.out)), 0);
    repeat (3) @(negedge clk);
    check("t6 no aborted out", longint'(pulses - p0), 0);
    beat(1, 1, 0, 4'h2, 4'h3, 0);
    expect_out("t6 after rst", 24, 1'b0);
    check("t6 pulse count", longint'(pulses - p0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
